// File: rtl/lsu_dmem_port.sv
// RV32I load/store port in front of a word-organised data memory; SB/SH are done as read-modify-write.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses are rejected instead of force-aligned.
module lsu_dmem_port #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH) + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [31:0]       mem_rd_dout,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_din,
    output logic              mem_we
);
    typedef enum logic [1:0] {IDLE, ACCESS, WRITE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_p0;
    logic [2:0]        funct3_p0;
    logic [31:0]       wdata_p0;
    logic              we_p0;
    logic [31:0]       merge_p1;
    logic [1:0]        lane;
    logic              illegal;
    logic              err;
    logic [ADDR_W-1:0] word_addr;
    logic              unused_addr_hi;

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] ln);
        logic [31:0]        shifted;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] ext;
        shifted = word >> {ln, 3'b000};
        b = shifted[7:0];
        h = shifted[15:0];
        case (f3)
            3'b000:  ext = b;
            3'b001:  ext = h;
            3'b100:  ext = {24'h0, shifted[7:0]};
            3'b101:  ext = {16'h0, shifted[15:0]};
            default: ext = word;
        endcase
        return ext;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                                input logic [2:0] f3, input logic [1:0] ln);
        logic [31:0] mask;
        logic [31:0] ins;
        if (f3[0]) begin
            mask = 32'h0000_FFFF << {ln, 3'b000};
            ins  = {16'h0, wd[15:0]} << {ln, 3'b000};
        end else begin
            mask = 32'h0000_00FF << {ln, 3'b000};
            ins  = {24'h0, wd[7:0]} << {ln, 3'b000};
        end
        return (word & ~mask) | (ins & mask);
    endfunction

    // Bits above the memory span are dropped at latch time so accesses wrap.
    assign unused_addr_hi = ^req_addr[31:ADDR_W];

    assign req_ready   = (state == IDLE);
    assign word_addr   = {addr_p0[ADDR_W-1:2], 2'b00};
    assign mem_rd_addr = word_addr;
    assign mem_wr_addr = word_addr;
    assign illegal     = we_p0 ? (funct3_p0[2] || funct3_p0 == 3'b011)
                               : (funct3_p0 == 3'b011 || funct3_p0[2:1] == 2'b11);

    // Halfword lane is forced even and word lane to zero; the trap build rejects these cases anyway.
    always_comb begin
        lane = addr_p0[1:0];
        case (funct3_p0[1:0])
            2'b01:   lane[0] = 1'b0;
            2'b10:   lane    = 2'b00;
            default: lane    = addr_p0[1:0];
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = (funct3_p0[1:0] == 2'b01 && addr_p0[0]) ||
                      (funct3_p0[1:0] == 2'b10 && addr_p0[1:0] != 2'b00);
    assign err = illegal || misalign;
`else
    assign err = illegal;
`endif

    assign mem_we     = (state == WRITE) ||
                        (state == ACCESS && we_p0 && !err && funct3_p0[1]);
    assign mem_wr_din = (state == WRITE) ? merge_p1 : wdata_p0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            addr_p0   <= '0;
            funct3_p0 <= '0;
            wdata_p0  <= '0;
            we_p0     <= 1'b0;
            merge_p1  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                // p0: request latch
                IDLE: begin
                    if (req_valid) begin
                        addr_p0   <= req_addr[ADDR_W-1:0];
                        funct3_p0 <= req_funct3;
                        wdata_p0  <= req_wdata;
                        we_p0     <= req_we;
                        state     <= ACCESS;
                    end
                end
                // p1: memory read, load extract, SW commit or RMW merge
                ACCESS: begin
                    if (err || !we_p0 || funct3_p0[1]) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= err;
                        rsp_rdata <= (err || we_p0) ? 32'h0 : load_extend(mem_rd_dout, funct3_p0, lane);
                        state     <= IDLE;
                    end else begin
                        merge_p1 <= store_merge(mem_rd_dout, wdata_p0, funct3_p0, lane);
                        state    <= WRITE;
                    end
                end
                // p2: merged word written back
                WRITE: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 32'h0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_dmem_port.sv
// Testbench for lsu_dmem_port: table of requests with a response scoreboard plus a reset-during-RMW sequence.
module tb_lsu_dmem_port;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [2:0]        req_funct3 = 3'b0;
    logic [31:0]       req_addr = 32'h0;
    logic [31:0]       req_wdata = 32'h0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [31:0]       mem_rd_dout;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [31:0]       mem_wr_din;
    logic              mem_we;

    logic [31:0] mem [DEPTH];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = 8'h0;
    logic [31:0] pre_data = 32'h0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wes;
    } vec_t;

    vec_t        vecs[$];
    logic [32:0] sb[$];

    always #5 clk = ~clk;

    lsu_dmem_port #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_rd_addr(mem_rd_addr), .mem_rd_dout(mem_rd_dout),
        .mem_wr_addr(mem_wr_addr), .mem_wr_din(mem_wr_din), .mem_we(mem_we)
    );

    assign mem_rd_dout = mem[mem_rd_addr[ADDR_W-1:2]];

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (mem_we) mem[mem_wr_addr[ADDR_W-1:2]] <= mem_wr_din;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_data = data;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input logic e, input int lat, input int wes);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
        v.rdata = rd; v.err = e; v.lat = lat; v.wes = wes;
        vecs.push_back(v);
    endtask

    // Called at a falling edge; returns at the falling edge where the response is seen.
    task automatic issue(input vec_t v);
        int n;
        int wes;
        logic [32:0] e;
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
        chk("req_ready", {31'h0, req_ready}, 32'h1);
        sb.push_back({v.err, v.rdata});
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0; wes = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (mem_we) wes++;
            if (rsp_valid) break;
        end
        e = sb.pop_front();
        chk("rsp_seen", {31'h0, rsp_valid}, 32'h1);
        chk("latency", 32'(n), 32'(v.lat));
        chk("mem_we_cycles", 32'(wes), 32'(v.wes));
        chk("rsp_rdata", rsp_rdata, e[31:0]);
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, e[32]});
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        preload(8'd0, 32'h8081_8283);
        preload(8'd4, 32'h1122_3344);
        preload(8'd8, 32'h0);
        preload(8'd12, 32'h5566_7788);
        @(negedge clk);
        rst = 1'b1;

        add(0, 3'b000, 32'h03, 0, 32'hFFFF_FF80, 0, 2, 0);
        add(0, 3'b100, 32'h03, 0, 32'h0000_0080, 0, 2, 0);
        add(0, 3'b001, 32'h02, 0, 32'hFFFF_8081, 0, 2, 0);
        add(0, 3'b010, 32'h00, 0, 32'h8081_8283, 0, 2, 0);
        add(0, 3'b101, 32'h00, 0, 32'h0000_8283, 0, 2, 0);
        add(0, 3'b000, 32'h00, 0, 32'hFFFF_FF83, 0, 2, 0);
        add(0, 3'b100, 32'h01, 0, 32'h0000_0082, 0, 2, 0);
        add(1, 3'b000, 32'h11, 32'h0000_00AB, 32'h0, 0, 3, 1);
        add(0, 3'b010, 32'h10, 0, 32'h1122_AB44, 0, 2, 0);
        add(1, 3'b001, 32'h12, 32'h0000_BEEF, 32'h0, 0, 3, 1);
        add(0, 3'b010, 32'h10, 0, 32'hBEEF_AB44, 0, 2, 0);
        add(1, 3'b010, 32'h20, 32'hDEAD_BEEF, 32'h0, 0, 2, 1);
        add(0, 3'b010, 32'h20, 0, 32'hDEAD_BEEF, 0, 2, 0);
        add(0, 3'b011, 32'h00, 0, 32'h0, 1, 2, 0);
        add(0, 3'b110, 32'h00, 0, 32'h0, 1, 2, 0);
        add(0, 3'b111, 32'h00, 0, 32'h0, 1, 2, 0);
        add(1, 3'b100, 32'h10, 32'hFFFF_FFFF, 32'h0, 1, 2, 0);
        add(1, 3'b011, 32'h10, 32'hFFFF_FFFF, 32'h0, 1, 2, 0);
        add(0, 3'b010, 32'h10, 0, 32'hBEEF_AB44, 0, 2, 0);
        add(0, 3'b010, 32'hFFFF_F410, 0, 32'hBEEF_AB44, 0, 2, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        add(0, 3'b010, 32'h21, 0, 32'h0, 1, 2, 0);
        add(1, 3'b001, 32'h23, 32'h0000_1234, 32'h0, 1, 2, 0);
        add(0, 3'b010, 32'h20, 0, 32'hDEAD_BEEF, 0, 2, 0);
        add(0, 3'b001, 32'h13, 0, 32'h0, 1, 2, 0);
`else
        add(0, 3'b010, 32'h21, 0, 32'hDEAD_BEEF, 0, 2, 0);
        add(1, 3'b001, 32'h23, 32'h0000_1234, 32'h0, 0, 3, 1);
        add(0, 3'b010, 32'h20, 0, 32'h1234_BEEF, 0, 2, 0);
        add(0, 3'b001, 32'h13, 0, 32'hFFFF_BEEF, 0, 2, 0);
`endif

        foreach (vecs[i]) issue(vecs[i]);

        @(negedge clk);
        chk("rsp_pulse_width", {31'h0, rsp_valid}, 32'h0);

        // Reset asserted while an SB sits in WRITE
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h30; req_wdata = 32'h0000_00AA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rmw_write_we", {31'h0, mem_we}, 32'h1);
        rst = 1'b0;
        #1;
        chk("rmw_rst_we", {31'h0, mem_we}, 32'h0);
        chk("rmw_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rmw_rst_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        chk("rmw_word_kept", mem[12], 32'h5566_7788);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'h0, req_ready}, 32'h1);
        chk("post_rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        begin
            vec_t v;
            v.we = 0; v.f3 = 3'b010; v.addr = 32'h30; v.wdata = 0;
            v.rdata = 32'h5566_7788; v.err = 0; v.lat = 2; v.wes = 0;
            issue(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lsu_dmem_port.md
# lsu_dmem_port

Load/store unit sitting directly upstream of the core's word-organised data memory (one combinational read port, one synchronous word-write port, byte addresses with the word index taken from addr[ADDR_W-1:2]). Accepts RV32I load/store requests from the execute stage and handles lane selection and sign/zero extension. Implements SB/SH as a two-step read-modify-write, because the memory only supports whole-word writes. Returns a one-cycle response pulse to the writeback stage.

## Interface
Parameters:
- DEPTH, 256, data memory depth in 32-bit words (power of two)
- ADDR_W, $clog2(DEPTH)+2, memory byte-address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data (lane 0 aligned)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data (0 for stores and errors)
- rsp_err  out  1  request rejected (illegal funct3 or misaligned)
- mem_rd_addr  out  ADDR_W  word-aligned byte address to memory read port
- mem_rd_dout  in  32  combinational read data
- mem_wr_addr  out  ADDR_W  word-aligned byte address to memory write port
- mem_wr_din  out  32  full write word
- mem_we  out  1  write enable

## Operation
- FSM states: IDLE, ACCESS, WRITE. req_ready = (state == IDLE). A request is accepted on a rising edge with req_valid && req_ready. At acceptance, addr, funct3, wdata and we are latched.
- IDLE -> ACCESS on accept.
- ACCESS:
  - mem_rd_addr = {addr[ADDR_W-1:2], 2'b00}; mem_wr_addr is the same value.
  - Load: extract a byte at lane addr[1:0] or a halfword at lane addr[1]. Sign-extend for 000/001; zero-extend for 100/101. Register the result into rsp_rdata with rsp_valid=1, then go to IDLE.
  - SW: mem_we=1, mem_wr_din=wdata; rsp_valid next cycle; go to IDLE.
  - SB/SH: capture mem_rd_dout into a merge register with wdata[7:0] or wdata[15:0] inserted at the target lane(s); go to WRITE. mem_we=0.
- WRITE: mem_we=1, mem_wr_din=merge register; rsp_valid next cycle; go to IDLE.
- Error, ACCESS only: no mem_we, rsp_valid=1, rsp_err=1, rsp_rdata=0, go to IDLE. Triggers:
  - illegal funct3: load 011/110/111, or store with funct3[2]=1 or 011
  - misalignment (see Configuration)
- Address bits at and above ADDR_W are ignored; accesses wrap modulo memory size.
- mem_we is decoded from state, never registered. It is 0 in IDLE.
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, latched request 0, merge register 0.
- Reset mid-operation: the FSM returns to IDLE immediately and an RMW in progress produces no write.

## Timing
- Accept at edge N. ACCESS occupies cycle N..N+1.
- Load or SW: rsp_valid high in cycle N+1..N+2 (latency 2 edges); SW memory write commits at edge N+1.
- SB/SH: WRITE occupies N+1..N+2, write commits at edge N+2, rsp_valid high N+2..N+3.
- Errors: rsp_valid at latency 2, no write.
- rsp_valid may be high in the same cycle as the next accept; back-to-back loads give one accept every 2 cycles.
- There is no response backpressure: the consumer must take rsp_* in the cycle rsp_valid is high.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: halfword accesses with addr[0]=1 and word accesses with addr[1:0]!=0 complete with rsp_err=1, no memory write, rsp_rdata=0.
- LSU_MISALIGN_TRAP_EN undefined: misaligned offsets are forced aligned (addr[0] cleared for H/HU, addr[1:0] cleared for W) and the access proceeds normally with rsp_err=0.

## Test plan
- Reset release, mem word 0 = 0x8081_8283: LB @0x3 -> rsp_rdata 0xFFFF_FF80. LBU @0x3 -> 0x0000_0080. LH @0x2 -> 0xFFFF_8081. LW @0x0 -> 0x8081_8283. Each response pulses at latency 2.
- Word at 0x10 = 0x1122_3344: SB 0xAB @0x11 -> word 0x1122_AB44 after WRITE. SH 0xBEEF @0x12 -> 0xBEEF_AB44. mem_we high exactly one cycle per store; rsp_valid at latency 3.
- SW 0xDEAD_BEEF @0x20 followed by back-to-back LW @0x20 -> second request accepted at the edge after rsp_valid; returns 0xDEAD_BEEF.
- With LSU_MISALIGN_TRAP_EN: LW @0x21 -> rsp_err=1, rsp_rdata 0. SH @0x23 -> rsp_err=1, memory unchanged. Without the macro: LW @0x21 returns the word at 0x20 with rsp_err=0.
- Illegal funct3 011 on a load and 100 on a store -> rsp_err=1, no mem_we, FSM back in IDLE with req_ready=1.
- Assert rst during the WRITE state of an SB -> mem_we drops asynchronously, target word unchanged, rsp_valid=0, req_ready=1 after reset release.
